// File: rtl/vend_credit_fsm.sv
// Vending credit controller: coin accumulation, timed dispense strobe and a change pulse train.
// Optional feature macro: VEND_SALES_COUNT_EN adds a saturating 16-bit sales counter output.
module vend_credit_fsm #(
    parameter int PRICE       = 15,
    parameter int MAX_CREDIT  = 50,
    parameter int CREDIT_W    = 6,
    parameter int DISP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin5,
    input  logic                coin10,
    input  logic                buy,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                busy,
`ifdef VEND_SALES_COUNT_EN
    output logic [15:0]         sales,
`endif
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam int CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    localparam logic [CREDIT_W:0]   VAL5      = (CREDIT_W+1)'(5);
    localparam logic [CREDIT_W:0]   VAL10     = (CREDIT_W+1)'(10);
    localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] STEP      = CREDIT_W'(5);
    localparam logic [CNT_W-1:0]    DISP_LOAD = CNT_W'(DISP_CYCLES - 1);

    state_t           st;
    logic [CNT_W-1:0] disp_cnt;

    logic              coin_any;
    logic [CREDIT_W:0] coin_val;
    logic [CREDIT_W:0] sum;
    logic              coin_fits;
    logic              price_ok;

    // Sum is one bit wider than credit so the ceiling compare can never see a wrapped value.
    always_comb begin
        coin_any  = coin5 | coin10;
        coin_val  = (coin5 ? VAL5 : '0) + (coin10 ? VAL10 : '0);
        sum       = {1'b0, credit} + coin_val;
        coin_fits = (sum <= MAX_C);
        price_ok  = (credit >= PRICE_C);
    end

    assign state = st;
    assign busy  = (st == DISPENSE) | (st == CHANGE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st           <= IDLE;
            credit       <= '0;
            dispense     <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            disp_cnt     <= '0;
`ifdef VEND_SALES_COUNT_EN
            sales        <= '0;
`endif
        end else begin
            coin_reject <= 1'b0;
            case (st)
                IDLE: begin
                    if (coin_any) begin
                        if (coin_fits) begin
                            credit <= sum[CREDIT_W-1:0];
                            st     <= COLLECT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (cancel) begin
                        // Entering CHANGE emits the first pulse on the same edge.
                        coin_reject  <= coin_any;
                        change_pulse <= 1'b1;
                        credit       <= credit - STEP;
                        st           <= CHANGE;
                    end else if (buy && price_ok) begin
                        coin_reject <= coin_any;
                        credit      <= credit - PRICE_C;
                        dispense    <= 1'b1;
                        disp_cnt    <= DISP_LOAD;
                        st          <= DISPENSE;
`ifdef VEND_SALES_COUNT_EN
                        if (sales != 16'hFFFF) begin
                            sales <= sales + 16'd1;
                        end
`endif
                    end else if (coin_any) begin
                        if (coin_fits) begin
                            credit <= sum[CREDIT_W-1:0];
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                DISPENSE: begin
                    coin_reject <= coin_any;
                    if (disp_cnt == '0) begin
                        dispense <= 1'b0;
                        if (credit != '0) begin
                            change_pulse <= 1'b1;
                            credit       <= credit - STEP;
                            st           <= CHANGE;
                        end else begin
                            st <= IDLE;
                        end
                    end else begin
                        disp_cnt <= disp_cnt - 1'b1;
                    end
                end
                CHANGE: begin
                    // change_pulse doubles as the phase toggle: high phase then low phase.
                    coin_reject <= coin_any;
                    if (change_pulse) begin
                        change_pulse <= 1'b0;
                    end else if (credit == '0) begin
                        st <= IDLE;
                    end else begin
                        change_pulse <= 1'b1;
                        credit       <= credit - STEP;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Directed bench for vend_credit_fsm with hand-computed expectations.
module tb_vend_credit_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin5 = 1'b0;
    logic       coin10 = 1'b0;
    logic       buy = 1'b0;
    logic       cancel = 1'b0;
    logic [5:0] credit;
    logic       dispense;
    logic       change_pulse;
    logic       coin_reject;
    logic       busy;
    logic [1:0] state;
`ifdef VEND_SALES_COUNT_EN
    logic [15:0] sales;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vend_credit_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .coin5        (coin5),
        .coin10       (coin10),
        .buy          (buy),
        .cancel       (cancel),
        .credit       (credit),
        .dispense     (dispense),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .busy         (busy),
`ifdef VEND_SALES_COUNT_EN
        .sales        (sales),
`endif
        .state        (state)
    );

    // Called at a falling edge; returns at the next falling edge with the result visible.
    task automatic drive(input logic c5, input logic c10, input logic b, input logic cn);
        coin5 = c5; coin10 = c10; buy = b; cancel = cn;
        @(negedge clk);
        coin5 = 1'b0; coin10 = 1'b0; buy = 1'b0; cancel = 1'b0;
    endtask

    // Observe from the current sample until IDLE, counting strobes and busy cycles.
    task automatic run_out(output int d, output int p, output int b, output int ok, output int alt);
        logic prev;
        d = 0; p = 0; b = 0; ok = 0; alt = 1; prev = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (state == 2'd0) begin
                ok = 1;
                break;
            end
            if (dispense) d++;
            if (change_pulse) p++;
            if (change_pulse && prev) alt = 0;
            prev = change_pulse;
            if (busy) b++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (credit !== 6'd0) begin errors++; $display("FAIL reset_credit: got %0d want 0", credit); end
        checks++; if ({dispense, change_pulse, coin_reject, busy} !== 4'b0000)
            begin errors++; $display("FAIL reset_flags: got %b want 0000", {dispense, change_pulse, coin_reject, busy}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_exact_sale;
        int d, p, b, ok, alt;
        drive(0, 1, 0, 0);
        checks++; if (credit !== 6'd10) begin errors++; $display("FAIL sale_c10: got %0d want 10", credit); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL sale_collect: got %0d want 1", state); end
        drive(1, 0, 0, 0);
        checks++; if (credit !== 6'd15) begin errors++; $display("FAIL sale_c15: got %0d want 15", credit); end
        drive(0, 0, 1, 0);
        checks++; if ({state, dispense, busy} !== 4'b1011) begin errors++; $display("FAIL sale_buy: got %b want 1011", {state, dispense, busy}); end
        checks++; if (credit !== 6'd0) begin errors++; $display("FAIL sale_credit0: got %0d want 0", credit); end
        run_out(d, p, b, ok, alt);
        checks++; if (ok !== 1) begin errors++; $display("FAIL sale_timeout: got %0d want 1", ok); end
        checks++; if (d !== 4) begin errors++; $display("FAIL sale_disp_cycles: got %0d want 4", d); end
        checks++; if (p !== 0) begin errors++; $display("FAIL sale_no_change: got %0d want 0", p); end
`ifdef VEND_SALES_COUNT_EN
        checks++; if (sales !== 16'd1) begin errors++; $display("FAIL sale_count: got %0d want 1", sales); end
`endif
    endtask

    task automatic test_change_after_sale;
        int d, p, b, ok, alt;
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        checks++; if (credit !== 6'd20) begin errors++; $display("FAIL chg_c20: got %0d want 20", credit); end
        drive(0, 0, 1, 0);
        checks++; if (credit !== 6'd5) begin errors++; $display("FAIL chg_c5: got %0d want 5", credit); end
        run_out(d, p, b, ok, alt);
        checks++; if (ok !== 1) begin errors++; $display("FAIL chg_timeout: got %0d want 1", ok); end
        checks++; if (d !== 4) begin errors++; $display("FAIL chg_disp_cycles: got %0d want 4", d); end
        checks++; if (p !== 1) begin errors++; $display("FAIL chg_pulses: got %0d want 1", p); end
        checks++; if (b !== 6) begin errors++; $display("FAIL chg_busy_cycles: got %0d want 6", b); end
        checks++; if (credit !== 6'd0) begin errors++; $display("FAIL chg_credit_end: got %0d want 0", credit); end
    endtask

    task automatic test_ceiling_cancel;
        int d, p, b, ok, alt;
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0);
        checks++; if (credit !== 6'd50) begin errors++; $display("FAIL ceil_c50: got %0d want 50", credit); end
        drive(1, 0, 0, 0);
        checks++; if (coin_reject !== 1'b1) begin errors++; $display("FAIL ceil_reject: got %b want 1", coin_reject); end
        checks++; if (credit !== 6'd50) begin errors++; $display("FAIL ceil_hold: got %0d want 50", credit); end
        drive(0, 0, 0, 0);
        checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL ceil_reject_1cyc: got %b want 0", coin_reject); end
        drive(0, 0, 0, 1);
        checks++; if ({state, change_pulse} !== 3'b111) begin errors++; $display("FAIL ceil_cancel: got %b want 111", {state, change_pulse}); end
        run_out(d, p, b, ok, alt);
        checks++; if (ok !== 1) begin errors++; $display("FAIL ceil_timeout: got %0d want 1", ok); end
        checks++; if (p !== 10) begin errors++; $display("FAIL ceil_pulses: got %0d want 10", p); end
        checks++; if (b !== 20) begin errors++; $display("FAIL ceil_change_cycles: got %0d want 20", b); end
        checks++; if (alt !== 1) begin errors++; $display("FAIL ceil_alternate: got %0d want 1", alt); end
        checks++; if (d !== 0) begin errors++; $display("FAIL ceil_no_disp: got %0d want 0", d); end
        checks++; if (credit !== 6'd0) begin errors++; $display("FAIL ceil_credit_end: got %0d want 0", credit); end
    endtask

    task automatic test_same_cycle;
        int d, p, b, ok, alt;
        drive(1, 1, 0, 0);
        checks++; if (credit !== 6'd15) begin errors++; $display("FAIL both_coins: got %0d want 15", credit); end
        drive(1, 0, 1, 0);
        checks++; if ({dispense, coin_reject} !== 2'b11) begin errors++; $display("FAIL buy_coin: got %b want 11", {dispense, coin_reject}); end
        checks++; if (credit !== 6'd0) begin errors++; $display("FAIL buy_coin_credit: got %0d want 0", credit); end
        run_out(d, p, b, ok, alt);
        checks++; if (ok !== 1 || d !== 4 || p !== 0)
            begin errors++; $display("FAIL buy_coin_runout: got ok=%0d d=%0d p=%0d want 1 4 0", ok, d, p); end
    endtask

    task automatic test_busy_reject;
        int d, p, b, ok, alt;
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        checks++; if ({dispense, coin_reject} !== 2'b11) begin errors++; $display("FAIL busy_reject: got %b want 11", {dispense, coin_reject}); end
        checks++; if (credit !== 6'd5) begin errors++; $display("FAIL busy_credit: got %0d want 5", credit); end
        run_out(d, p, b, ok, alt);
        checks++; if (ok !== 1 || d !== 3 || p !== 1)
            begin errors++; $display("FAIL busy_runout: got ok=%0d d=%0d p=%0d want 1 3 1", ok, d, p); end
    endtask

    task automatic test_cancel_priority;
        int d, p, b, ok, alt;
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        checks++; if ({state, dispense} !== 3'b010) begin errors++; $display("FAIL low_buy: got %b want 010", {state, dispense}); end
        checks++; if (credit !== 6'd5) begin errors++; $display("FAIL low_buy_credit: got %0d want 5", credit); end
        drive(0, 0, 1, 1);
        checks++; if ({state, change_pulse, dispense} !== 4'b1110) begin errors++; $display("FAIL cancel_wins: got %b want 1110", {state, change_pulse, dispense}); end
        run_out(d, p, b, ok, alt);
        checks++; if (ok !== 1 || d !== 0 || p !== 1)
            begin errors++; $display("FAIL cancel_runout: got ok=%0d d=%0d p=%0d want 1 0 1", ok, d, p); end
    endtask

    task automatic test_async_reset;
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 0);
        @(negedge clk);
        checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL ar_disp2: got %b want 1", dispense); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({dispense, credit} !== 7'd0) begin errors++; $display("FAIL ar_clear: got disp=%b credit=%0d want 0 0", dispense, credit); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL ar_state: got %0d want 0", state); end
`ifdef VEND_SALES_COUNT_EN
        checks++; if (sales !== 16'd0) begin errors++; $display("FAIL ar_sales: got %0d want 0", sales); end
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_exact_sale();
        test_change_after_sale();
        test_ceiling_cancel();
        test_same_cycle();
        test_busy_reject();
        test_cancel_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_credit_fsm.md
Name: vend_credit_fsm

Overview:
- Consumes the one-cycle pulses from the per-button debounce stages: coin 5, coin 10, buy and cancel.
- Accumulates credit and drives the dispense strobe.
- Returns change as a train of 5-unit pulses.
- Sits between the button debouncers and the display/actuator logic.

Parameters:
PRICE, 15, item price in currency units; must be a nonzero multiple of 5 and <= MAX_CREDIT
MAX_CREDIT, 50, credit ceiling; must be a multiple of 5 and < 2**CREDIT_W
CREDIT_W, 6, width of credit register and output
DISP_CYCLES, 4, cycles dispense is held high; must be >= 1

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
coin5  in  1  one-cycle pulse, 5-unit coin inserted
coin10  in  1  one-cycle pulse, 10-unit coin inserted
buy  in  1  one-cycle pulse, purchase request
cancel  in  1  one-cycle pulse, refund request
credit  out  CREDIT_W  current credit, registered
dispense  out  1  high for DISP_CYCLES cycles per sale
change_pulse  out  1  one pulse per 5 units returned
coin_reject  out  1  one-cycle pulse, coin(s) refused this cycle
busy  out  1  high in DISPENSE or CHANGE
state  out  2  IDLE=0, COLLECT=1, DISPENSE=2, CHANGE=3

Behaviour:
- Reset (asynchronous, any state, including mid-dispense or mid-change):
  - state=IDLE, credit=0, dispense=0, change_pulse=0, coin_reject=0, busy=0.
  - All internal counters and the change-phase toggle cleared.
- Registered outputs: every input acts on the next rising edge; outputs reflect the result one cycle after the input pulse.
- Coin value this cycle: coin5 adds 5, coin10 adds 10; both together add 15.
- IDLE: credit is 0.
  - Accepted coin: credit += value, go to COLLECT.
  - buy or cancel: ignored.
- COLLECT, priority cancel > buy > coins:
  - cancel: go to CHANGE (credit > 0 always holds here). Coins in the same cycle are rejected.
  - buy with credit >= PRICE: credit -= PRICE, dispense=1, go to DISPENSE. Same-cycle coins are rejected.
  - buy with credit < PRICE: no state change. Same-cycle coins are still processed normally.
  - Coin with credit + value <= MAX_CREDIT: credit += value.
  - Coin with credit + value > MAX_CREDIT: the whole cycle's value is refused, credit unchanged, coin_reject=1 for one cycle.
- DISPENSE:
  - dispense stays high for exactly DISP_CYCLES cycles.
  - Then: credit > 0 goes to CHANGE with dispense=0; credit = 0 goes to IDLE.
- CHANGE, alternating phases, first phase is the high phase:
  - High phase: change_pulse=1, credit -= 5.
  - Low phase: change_pulse=0.
  - After the low phase that follows the pulse bringing credit to 0, go to IDLE.
  - N units of credit produce N/5 pulses over 2*N/5 cycles.
- In DISPENSE and CHANGE, every coin pulse is refused with coin_reject=1; buy and cancel are ignored.
- Credit arithmetic:
  - Addition is done at CREDIT_W+1 bits before the ceiling compare, so wrap-around is impossible.
  - credit is always a multiple of 5 and never underflows.
- busy = (state == DISPENSE) | (state == CHANGE).

Optional Feature:
Macro VEND_SALES_COUNT_EN.
- Defined:
  - Adds output port sales (16 bits), reset to 0.
  - Increments by 1 on each COLLECT-to-DISPENSE transition.
  - Saturates at 16'hFFFF.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- reset pulse, then coin10, coin5 on separate cycles, then buy (PRICE=15) -> credit 10 then 15; dispense high 4 cycles; credit 0; state returns to IDLE; no change_pulse.
- coin10 x2, buy -> credit 20 -> 5; dispense 4 cycles; then exactly 1 change_pulse; credit 0; IDLE.
- coin10 x5 (credit 50), then coin5 -> coin_reject=1 one cycle; credit stays 50; cancel -> 10 change_pulse high cycles, alternating with low cycles; credit ends at 0.
- coin5 and coin10 in the same cycle from IDLE -> credit 15; buy and coin5 in the same cycle -> dispense, coin_reject=1, credit 0.
- coin5, then buy -> ignored, credit 5; then cancel and buy in the same cycle -> CHANGE wins, 1 change_pulse, no dispense.
- credit 20, buy, assert reset in the 2nd dispense cycle -> dispense=0 and credit=0 immediately (asynchronous); state IDLE; with VEND_SALES_COUNT_EN, sales also 0.
